// File: rtl/ddr3_cmd_responder_if.sv
// Command/data bus between a DDR3 controller model (master) and the
// single-rank command responder (slave).
interface ddr3_cmd_responder_if;
  logic        CS;
  logic        RAS;
  logic        CAS;
  logic        WE;
  logic [14:0] Addr_in;
  logic [2:0]  BA_in;
  logic [7:0]  DQ_in;
  logic        LDM;
  logic [7:0]  DQ_out;
  logic        DQ_oe;
  logic        DQS_out;
  logic [7:0]  Bank_open;
  logic        Error;
  logic [2:0]  state;

  modport master (
    output CS, RAS, CAS, WE, Addr_in, BA_in, DQ_in, LDM,
    input  DQ_out, DQ_oe, DQS_out, Bank_open, Error, state
  );

  modport slave (
    input  CS, RAS, CAS, WE, Addr_in, BA_in, DQ_in, LDM,
    output DQ_out, DQ_oe, DQS_out, Bank_open, Error, state
  );
endinterface

// File: rtl/ddr3_cmd_responder.sv
// Behavioural DDR3 command responder: tracks open banks, runs fixed-length
// BL8 read/write bursts after CL/CWL latency against a 64-byte store.
module ddr3_cmd_responder #(
  parameter int CL  = 5,
  parameter int CWL = 5
) (
  input  logic                 CLK,
  input  logic                 Reset_input,
  ddr3_cmd_responder_if.slave  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_WAIT  = 3'd1;
  localparam logic [2:0] WR_BURST = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RD_BURST = 3'd4;

  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;

  // Write bursts enter WR_BURST one edge before the first sample edge.
  localparam logic [3:0] RD_LAT_LOAD = 4'(CL - 1);
  localparam logic [3:0] WR_LAT_LOAD = 4'(CWL - 2);

  logic [2:0] state_reg;
  logic [3:0] lat_cnt_reg;
  logic [2:0] beat_cnt_reg;
  logic [2:0] burst_bank_reg;
  logic       auto_pre_reg;
  logic       error_reg;
  logic [7:0] dq_out_reg;
  logic       dq_oe_reg;
  logic       dqs_reg;
  logic [7:0] bank_open;
  logic [7:0] row_parity_unused;
  logic [7:0] mem [0:63];

  logic [2:0] cmd;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_rw;
  logic       busy, rw_ok, burst_done, err_set, mem_we;
  logic [2:0] rd_beat;

  assign cmd    = {bus.RAS, bus.CAS, bus.WE};
  assign is_act = !bus.CS && (cmd == CMD_ACT);
  assign is_rd  = !bus.CS && (cmd == CMD_READ);
  assign is_wr  = !bus.CS && (cmd == CMD_WRITE);
  assign is_pre = !bus.CS && (cmd == CMD_PRE);
  assign is_ref = !bus.CS && (cmd == CMD_REF);
  assign is_rw  = is_rd || is_wr;

  assign busy       = (state_reg != IDLE);
  assign rw_ok      = is_rw && !busy && bank_open[bus.BA_in];
  assign burst_done = ((state_reg == WR_BURST) || (state_reg == RD_BURST)) &&
                      (beat_cnt_reg == 3'd7);

  assign err_set = (is_act && bank_open[bus.BA_in]) ||
                   (is_ref && (|bank_open)) ||
                   (is_rw && (busy || !bank_open[bus.BA_in])) ||
                   (is_pre && busy && (bus.Addr_in[10] || (bus.BA_in == burst_bank_reg)));

  // Next beat to present: beat 0 on the latency-expiry edge, else the following one.
  assign rd_beat = (state_reg == RD_WAIT) ? 3'd0 : beat_cnt_reg + 3'd1;
  assign mem_we  = !Reset_input && (state_reg == WR_BURST) && !bus.LDM;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bank
      logic        open_reg;
      logic [14:0] row_reg;
      logic        act_hit;
      logic        close_hit;

      assign act_hit   = is_act && (bus.BA_in == 3'(gi)) && !open_reg;
      assign close_hit = (is_pre && (bus.Addr_in[10] || (bus.BA_in == 3'(gi)))) ||
                         (burst_done && auto_pre_reg && (burst_bank_reg == 3'(gi)));

      always_ff @(posedge CLK) begin
        if (Reset_input) begin
          open_reg <= 1'b0;
          row_reg  <= '0;
        end else if (act_hit) begin
          open_reg <= 1'b1;
          row_reg  <= bus.Addr_in;
        end else if (close_hit) begin
          open_reg <= 1'b0;
        end
      end

      assign bank_open[gi]         = open_reg;
      assign row_parity_unused[gi] = ^row_reg;
    end
  endgenerate

  // Storage is deliberately outside reset so data survives an aborted burst.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[{burst_bank_reg, beat_cnt_reg}] <= bus.DQ_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset_input) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      beat_cnt_reg   <= '0;
      burst_bank_reg <= '0;
      auto_pre_reg   <= 1'b0;
      error_reg      <= 1'b0;
      dq_out_reg     <= '0;
      dq_oe_reg      <= 1'b0;
      dqs_reg        <= 1'b0;
    end else begin
      if (err_set) begin
        error_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (rw_ok) begin
            burst_bank_reg <= bus.BA_in;
            auto_pre_reg   <= bus.Addr_in[10];
            beat_cnt_reg   <= '0;
            if (is_wr) begin
              state_reg   <= WR_WAIT;
              lat_cnt_reg <= WR_LAT_LOAD;
            end else begin
              state_reg   <= RD_WAIT;
              lat_cnt_reg <= RD_LAT_LOAD;
            end
          end
        end
        WR_WAIT: begin
          if (lat_cnt_reg == 4'd0) begin
            state_reg    <= WR_BURST;
            beat_cnt_reg <= '0;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        WR_BURST: begin
          if (beat_cnt_reg == 3'd7) begin
            state_reg <= IDLE;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + 3'd1;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_reg == 4'd0) begin
            state_reg    <= RD_BURST;
            beat_cnt_reg <= '0;
            dq_out_reg   <= mem[{burst_bank_reg, rd_beat}];
            dq_oe_reg    <= 1'b1;
            dqs_reg      <= 1'b1;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        RD_BURST: begin
          if (beat_cnt_reg == 3'd7) begin
            state_reg  <= IDLE;
            dq_out_reg <= '0;
            dq_oe_reg  <= 1'b0;
            dqs_reg    <= 1'b0;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + 3'd1;
            dq_out_reg   <= mem[{burst_bank_reg, rd_beat}];
            dqs_reg      <= ~dqs_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.DQ_out    = dq_out_reg;
  assign bus.DQ_oe     = dq_oe_reg;
  assign bus.DQS_out   = dqs_reg;
  assign bus.Bank_open = bank_open;
  assign bus.Error     = error_reg;
  assign bus.state     = state_reg;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: bank bookkeeping, BL8 write/read
// bursts with masking, auto-precharge, protocol errors and mid-burst reset.
module tb_ddr3_cmd_responder;

  localparam int CL  = 5;
  localparam int CWL = 5;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;

  logic CLK = 1'b0;
  logic Reset_input;
  int   n_cmp = 0;
  int   n_err = 0;

  ddr3_cmd_responder_if bus();

  ddr3_cmd_responder #(.CL(CL), .CWL(CWL)) dut (
    .CLK         (CLK),
    .Reset_input (Reset_input),
    .bus         (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    bus.CS = 1'b1;
    {bus.RAS, bus.CAS, bus.WE} = 3'b111;
  endtask

  task automatic set_cmd(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a);
    bus.CS = 1'b0;
    {bus.RAS, bus.CAS, bus.WE} = c;
    bus.BA_in   = ba;
    bus.Addr_in = a;
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a);
    set_cmd(c, ba, a);
    step();
    nop();
  endtask

  task automatic do_reset();
    Reset_input = 1'b1;
    step();
    Reset_input = 1'b0;
  endtask

  task automatic write_burst(input logic [2:0] ba, input logic [7:0] base,
                             input logic [7:0] inc, input logic [7:0] mask);
    $display("write bank %0d base 0x%02h inc %0d mask 0x%02h", ba, base, inc, mask);
    issue(C_WR, ba, 15'd1);
    chk("wr_state_wait", 64'(bus.state), 64'd1);
    repeat (CWL - 1) step();
    chk("wr_state_burst", 64'(bus.state), 64'd2);
    for (int k = 0; k < 8; k++) begin
      bus.DQ_in = base + inc * 8'(k);
      bus.LDM   = mask[k];
      step();
    end
    bus.LDM   = 1'b0;
    bus.DQ_in = '0;
    chk("wr_state_done", 64'(bus.state), 64'd0);
  endtask

  task automatic read_check(input logic [2:0] ba, input logic ap, input logic dup,
                            input logic [63:0] exp);
    $display("read bank %0d ap %0d dup %0d expect 0x%016h", ba, ap, dup, exp);
    issue(C_RD, ba, {4'd0, ap, 10'd1});
    chk("rd_state_wait", 64'(bus.state), 64'd3);
    for (int i = 0; i < CL - 1; i++) begin
      if (dup && i == 1) set_cmd(C_RD, ba, 15'd1);
      step();
      nop();
    end
    chk("rd_oe_before", 64'(bus.DQ_oe), 64'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rd_oe[%0d]", k), 64'(bus.DQ_oe), 64'd1);
      chk($sformatf("rd_data[%0d]", k), 64'(bus.DQ_out), 64'(exp[8*k +: 8]));
      chk($sformatf("rd_dqs[%0d]", k), 64'(bus.DQS_out), 64'((k % 2) == 0));
    end
    chk("rd_open_last_beat", 64'(bus.Bank_open[ba]), 64'd1);
    step();
    chk("rd_oe_after", 64'(bus.DQ_oe), 64'd0);
    chk("rd_state_idle", 64'(bus.state), 64'd0);
    chk("rd_dqs_after", 64'(bus.DQS_out), 64'd0);
    chk("rd_autopre", 64'(bus.Bank_open[ba]), 64'(!ap));
  endtask

  initial begin
    Reset_input = 1'b1;
    nop();
    bus.Addr_in = '0;
    bus.BA_in   = '0;
    bus.DQ_in   = '0;
    bus.LDM     = 1'b0;
    step();
    step();
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_bank_open", 64'(bus.Bank_open), 64'd0);
    chk("rst_error", 64'(bus.Error), 64'd0);
    chk("rst_oe", 64'(bus.DQ_oe), 64'd0);
    chk("rst_dq", 64'(bus.DQ_out), 64'd0);
    chk("rst_dqs", 64'(bus.DQS_out), 64'd0);
    Reset_input = 1'b0;

    // Fill, masked overwrite, full overwrite of bank 5.
    issue(C_ACT, 3'd5, 15'd5);
    chk("act5_open", 64'(bus.Bank_open), 64'h20);
    write_burst(3'd5, 8'h11, 8'd0, 8'h00);
    write_burst(3'd5, 8'hA0, 8'd1, 8'b0010_0100);
    read_check(3'd5, 1'b0, 1'b0, 64'hA7A6_11A4_A311_A1A0);
    write_burst(3'd5, 8'hA0, 8'd1, 8'h00);
    read_check(3'd5, 1'b0, 1'b0, 64'hA7A6_A5A4_A3A2_A1A0);
    chk("data_error_clear", 64'(bus.Error), 64'd0);

    // Second READ while the first is in flight.
    read_check(3'd5, 1'b0, 1'b1, 64'hA7A6_A5A4_A3A2_A1A0);
    chk("dup_read_error", 64'(bus.Error), 64'd1);

    // Reset on the fourth beat of a read.
    $display("read bank 5 with reset at beat 3");
    issue(C_RD, 3'd5, 15'd1);
    repeat (CL - 1) step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_rd_data[%0d]", k), 64'(bus.DQ_out), 64'(8'hA0 + 8'(k)));
    end
    Reset_input = 1'b1;
    step();
    Reset_input = 1'b0;
    chk("rst_rd_oe", 64'(bus.DQ_oe), 64'd0);
    chk("rst_rd_state", 64'(bus.state), 64'd0);
    chk("rst_rd_open", 64'(bus.Bank_open), 64'd0);
    chk("rst_rd_error", 64'(bus.Error), 64'd0);

    // READ to a closed bank.
    $display("read closed bank 3");
    issue(C_RD, 3'd3, 15'd1);
    chk("closed_rd_error", 64'(bus.Error), 64'd1);
    chk("closed_rd_state", 64'(bus.state), 64'd0);
    repeat (CL + 1) step();
    chk("closed_rd_oe", 64'(bus.DQ_oe), 64'd0);
    do_reset();

    // Reset on beat 3 of a write: beats 0..2 land, beat 3 onward keep old data.
    $display("write bank 5 with reset at beat 3");
    issue(C_ACT, 3'd5, 15'd9);
    issue(C_WR, 3'd5, 15'd1);
    repeat (CWL - 1) step();
    bus.DQ_in = 8'h55;
    repeat (3) step();
    Reset_input = 1'b1;
    step();
    Reset_input = 1'b0;
    bus.DQ_in = '0;
    chk("rst_wr_state", 64'(bus.state), 64'd0);

    // Auto-precharge read, then READ to the now-closed bank.
    issue(C_ACT, 3'd5, 15'd9);
    read_check(3'd5, 1'b1, 1'b0, 64'hA7A6_A5A4_A355_5555);
    chk("ap_error_clear", 64'(bus.Error), 64'd0);
    issue(C_RD, 3'd5, 15'd1);
    chk("ap_reread_error", 64'(bus.Error), 64'd1);
    chk("ap_reread_state", 64'(bus.state), 64'd0);
    do_reset();

    // Bank bookkeeping and REF/PRE/ACT legality.
    $display("bank open/close sequence");
    issue(C_REF, 3'd0, 15'd0);
    chk("ref_idle_error", 64'(bus.Error), 64'd0);
    issue(C_ACT, 3'd2, 15'h0123);
    issue(C_ACT, 3'd6, 15'h0456);
    chk("act26_open", 64'(bus.Bank_open), 64'h44);
    issue(C_PRE, 3'd2, 15'd0);
    chk("pre2_open", 64'(bus.Bank_open), 64'h40);
    issue(C_PRE, 3'd2, 15'd0);
    chk("pre_closed_error", 64'(bus.Error), 64'd0);
    issue(C_REF, 3'd0, 15'd0);
    chk("ref_open_error", 64'(bus.Error), 64'd1);
    chk("ref_open_banks", 64'(bus.Bank_open), 64'h40);
    do_reset();
    issue(C_ACT, 3'd1, 15'd7);
    issue(C_ACT, 3'd1, 15'd8);
    chk("act_twice_error", 64'(bus.Error), 64'd1);
    chk("act_twice_open", 64'(bus.Bank_open), 64'h02);
    issue(C_ACT, 3'd7, 15'd3);
    issue(C_PRE, 3'd0, 15'h0400);
    chk("pre_all_open", 64'(bus.Bank_open), 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
